// File: rtl/fp16_accum_ctrl.sv
// Sequencer that folds a stream of fp16 operands onto a bias through an
// external combinational fp16 adder, emitting one partial sum per job.
module fp16_accum_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      bias,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [LEN_W-1:0] rem;
  logic             ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      rem       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= bias;
            rem  <= len;
            ovf  <= 1'b0;
            busy <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc <= add_sum;
            rem <= rem - LEN_W'(1);
            ovf <= ovf | (&add_sum[14:10]);
            // Exit on the last operand so rem never has to wrap below zero.
            if (rem == LEN_W'(1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign add_a    = acc;
  assign add_b    = (state == ACCUM) ? in_data : 16'h0000;
  assign out_data = acc;
  assign out_ovf  = ovf;

endmodule

// File: tb/tb_fp16_accum_ctrl.sv
// Bench for fp16_accum_ctrl: supplies a behavioural fp16 adder and checks each
// job against a queue-fold reference of the operand stream.
module tb_fp16_accum_ctrl;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      bias;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic [15:0]      add_sum;
  logic             out_valid;
  logic [15:0]      out_data;
  logic             out_ovf;
  logic             out_ready;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] ops_q[$];
  logic [15:0] last_res;
  logic        last_ovf;

  fp16_accum_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 31) m = 1.0e30;
    else if (e == 0) m = 0.0;
    else begin
      m = 1.0 + real'(h[9:0]) / 1024.0;
      for (int k = 15; k < e; k++) m = m * 2.0;
      for (int k = e; k < 15; k++) m = m / 2.0;
    end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  a;
    int   e;
    int   m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a >= 65520.0) return {s, 5'h1f, 10'h000};
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e <= 0) return 16'h0000;
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    if (e >= 31) return {s, 5'h1f, 10'h000};
    return {s, 5'(e), 10'(m)};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b));
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic [15:0] v;
    v = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 19)), 10'($urandom)};
    return v;
  endfunction

  always_comb add_sum = fp_add(add_a, add_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one job from ops_q; vmask bit k is in_valid for the k-th ACCUM cycle.
  task automatic run_job(input logic [15:0] b, input int n, input logic [31:0] vmask,
                         input int bp, input logic rand_start);
    logic [15:0] exp_acc;
    logic        exp_ovf;
    int          i;
    int          k;
    int          guard;
    exp_acc = b;
    exp_ovf = 1'b0;
    start = 1'b1;
    len   = LEN_W'(n);
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    len   = LEN_W'($urandom);
    bias  = 16'($urandom);
    check("busy_after_start", busy, 1);
    check("ovf_cleared", out_ovf, 0);
    i = 0; k = 0; guard = 0;
    while (i < n && guard < n + 64) begin
      in_valid = (k < 32) ? vmask[k] : 1'b1;
      k++;
      in_data = ops_q[i];
      if (rand_start) start = 1'($urandom_range(0, 1));
      #1;
      check("in_ready_accum", in_ready, 1);
      check("out_valid_accum", out_valid, 0);
      check("add_a_acc", add_a, exp_acc);
      check("add_b_accum", add_b, ops_q[i]);
      if (in_valid) begin
        exp_acc = fp_add(exp_acc, ops_q[i]);
        exp_ovf = exp_ovf | (exp_acc[14:10] == 5'h1f);
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (i < n) check("accept_timeout", i, n);
    check("out_valid_rise", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("out_data", out_data, exp_acc);
    check("out_ovf", out_ovf, exp_ovf);
    repeat (bp) begin
      if (rand_start) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_acc);
      check("hold_ovf", out_ovf, exp_ovf);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consumed_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    last_res = exp_acc;
    last_ovf = exp_ovf;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; bias = 16'h0000;
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_add_a", add_a, 16'h0000);
    check("rst_add_b", add_b, 16'h0000);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    // Basic accumulate.
    ops_q = '{16'h3C00, 16'h3C00, 16'h3C00};
    run_job(16'h0000, 3, 32'hFFFF_FFFF, 0, 1'b0);
    check("basic_sum", last_res, 16'h4200);
    check("basic_ovf", last_ovf, 0);

    // Bias with exact cancellation.
    ops_q = '{16'hBC00, 16'h3800};
    run_job(16'h3C00, 2, 32'hFFFF_FFFF, 0, 1'b0);
    check("cancel_sum", last_res, 16'h3800);

    // Stalls, backpressure and ignored starts.
    ops_q = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    run_job(16'h0000, 4, 32'h0000_0035, 3, 1'b1);
    check("stall_sum", last_res, 16'h4400);

    // Zero-length job.
    ops_q.delete();
    run_job(16'h4000, 0, 32'hFFFF_FFFF, 0, 1'b0);
    check("zero_len", last_res, 16'h4000);

    // Overflow stays sticky while idle.
    ops_q = '{16'h7BFF, 16'h3C00};
    run_job(16'h7BFF, 2, 32'hFFFF_FFFF, 1, 1'b0);
    check("ovf_set", last_ovf, 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("ovf_sticky", out_ovf, 1);
    end

    // Reset in the middle of a job.
    start = 1'b1; len = LEN_W'(5); bias = 16'h0000;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'h3C00;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_add_a", add_a, 16'h4000);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 16'h0000);
    check("arst_out_ovf", out_ovf, 0);
    check("arst_busy", busy, 0);
    check("arst_add_a", add_a, 16'h0000);
    check("arst_add_b", add_b, 16'h0000);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    ops_q = '{16'h4000};
    run_job(16'h0000, 1, 32'hFFFF_FFFF, 0, 1'b0);
    check("post_rst_sum", last_res, 16'h4000);

    // Back-to-back jobs with a single idle cycle between them.
    ops_q = '{16'h3C00, 16'h3C00, 16'h3C00};
    run_job(16'h0000, 3, 32'hFFFF_FFFF, 0, 1'b0);
    check("b2b_first", last_res, 16'h4200);
    ops_q = '{16'h3C00};
    run_job(16'h0000, 1, 32'hFFFF_FFFF, 0, 1'b0);
    check("b2b_second", last_res, 16'h3C00);

    // Longest job the count width allows.
    ops_q.delete();
    for (int q = 0; q < 255; q++) ops_q.push_back(16'h3C00);
    run_job(16'h0000, 255, $urandom, 1, 1'b1);
    check("max_len_sum", last_res, 16'h5BF8);

    for (int j = 0; j < 20; j++) begin
      int          n;
      logic [15:0] b;
      n = $urandom_range(0, 12);
      b = rnd_fp();
      ops_q.delete();
      for (int q = 0; q < n; q++) ops_q.push_back(rnd_fp());
      run_job(b, n, $urandom, $urandom_range(0, 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
